// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU datapath constants and the writeback-entry type
//               used by the register write buffer and its forwarding search.
// Contents    : ADDR_W   - register index width
//               DATA_W   - register data width
//               REG_ZERO - index of the hard-wired zero register
//               wb_entry_t {rw, data} - one buffered writeback request
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_fwd_match
// Description : Combinational youngest-match search for one decode read port.
//               Looks at the write-buffer output stage (oldest) followed by
//               the queue entries presented in age order (index 0 = oldest).
//               The youngest matching entry supplies the forwarded value.
// Ports       : i_ra                     - read address being looked up
//               i_out_vld/i_out_rw/i_out_data - output stage (RegWr/Rw/busW)
//               i_ent_vld/i_ent_rw/i_ent_data - queue entries, oldest first
//               o_hit                    - a pending write targets i_ra
//               o_data                   - youngest pending value, 0 on miss
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0]             i_ra,
    input  logic                          i_out_vld,
    input  logic [ADDR_W-1:0]             i_out_rw,
    input  logic [DATA_W-1:0]             i_out_data,
    input  logic [DEPTH-1:0]              i_ent_vld,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  i_ent_rw,
    input  logic [DEPTH-1:0][DATA_W-1:0]  i_ent_data,
    output logic                          o_hit,
    output logic [DATA_W-1:0]             o_data
);

    import cpu_pkg::*;

    // Walk oldest to youngest; each later match overrides an earlier one so
    // the final value is the youngest pending write.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        if (i_out_vld && (i_out_rw == i_ra)) begin
            o_hit  = 1'b1;
            o_data = i_out_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i_ent_vld[i] && (i_ent_rw[i] == i_ra)) begin
                o_hit  = 1'b1;
                o_data = i_ent_data[i];
            end
        end
        // r0 reads are always zero in the register file, never forward.
        if (i_ra == ADDR_W'(REG_ZERO)) begin
            o_hit  = 1'b0;
            o_data = '0;
        end
    end

endmodule : wb_fwd_match
`default_nettype wire

// File: rtl/reg_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_buffer
// Description : In-order writeback queue in front of the register file write
//               port. Accepts one request per cycle, drains one per cycle when
//               the write port is free, and forwards pending values to the
//               decode read ports.
// Ports       : clk, rst_n              - clock, async active-low reset
//               in_valid/in_ready       - request handshake (in_ready = !full)
//               in_rw/in_data           - destination register and value
//               port_free               - register file write port available
//               RegWr/Rw/busW           - registered write port to registers
//               Ra/Rb                   - decode read addresses
//               hitA/fwdA, hitB/fwdB    - forwarding result per read port
//               count/empty/full        - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_rw,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         port_free,
    output logic                         RegWr,
    output logic [ADDR_W-1:0]            Rw,
    output logic [DATA_W-1:0]            busW,
    input  logic [ADDR_W-1:0]            Ra,
    input  logic [ADDR_W-1:0]            Rb,
    output logic                         hitA,
    output logic                         hitB,
    output logic [DATA_W-1:0]            fwdA,
    output logic [DATA_W-1:0]            fwdB,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic                         full
);

    import cpu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_regwr;
    logic [ADDR_W-1:0]  r_rw;
    logic [DATA_W-1:0]  r_busw;

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    logic [DEPTH-1:0]             w_ord_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] w_ord_rw;
    logic [DEPTH-1:0][DATA_W-1:0] w_ord_data;

    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    // Readiness looks at occupancy only, so a full buffer stays closed even
    // in a cycle where it also pops.
    assign w_accept = in_valid && !w_full;
    // A write to r0 completes the handshake but is never stored.
    assign w_push   = w_accept && (in_rw != ADDR_W'(REG_ZERO));
    assign w_pop    = port_free && !w_empty;

    // Payload storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{rw: in_rw, data: in_data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: Rw/busW hold their last value when nothing drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwr <= 1'b0;
            r_rw    <= '0;
            r_busw  <= '0;
        end else begin
            r_regwr <= w_pop;
            if (w_pop) begin
                r_rw   <= r_mem[r_head].rw;
                r_busw <= r_mem[r_head].data;
            end
        end
    end

    // Present the queue to the forwarding search in age order, oldest first.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_age
            logic [PTR_W-1:0] w_idx;
            assign w_idx         = r_head + PTR_W'(i);
            assign w_ord_vld[i]  = (CNT_W'(i) < r_count);
            assign w_ord_rw[i]   = r_mem[w_idx].rw;
            assign w_ord_data[i] = r_mem[w_idx].data;
        end
    endgenerate

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_a (
        .i_ra       (Ra),
        .i_out_vld  (r_regwr),
        .i_out_rw   (r_rw),
        .i_out_data (r_busw),
        .i_ent_vld  (w_ord_vld),
        .i_ent_rw   (w_ord_rw),
        .i_ent_data (w_ord_data),
        .o_hit      (hitA),
        .o_data     (fwdA)
    );

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_b (
        .i_ra       (Rb),
        .i_out_vld  (r_regwr),
        .i_out_rw   (r_rw),
        .i_out_data (r_busw),
        .i_ent_vld  (w_ord_vld),
        .i_ent_rw   (w_ord_rw),
        .i_ent_data (w_ord_data),
        .o_hit      (hitB),
        .o_data     (fwdB)
    );

    assign in_ready = !w_full;
    assign RegWr    = r_regwr;
    assign Rw       = r_rw;
    assign busW     = r_busw;
    assign count    = r_count;
    assign empty    = w_empty;
    assign full     = w_full;

endmodule : reg_write_buffer
`default_nettype wire

// File: tb/tb_reg_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_buffer
// Description : Directed self-checking bench for reg_write_buffer with a
//               behavioural register file fed from RegWr/Rw/busW.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rw;
    logic [31:0] in_data;
    logic        port_free;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic        hitA;
    logic        hitB;
    logic [31:0] fwdA;
    logic [31:0] fwdB;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_pass;
    int n_checks;

    logic [31:0] rf [32];

    reg_write_buffer #(
        .DEPTH  (4),
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rw     (in_rw),
        .in_data   (in_data),
        .port_free (port_free),
        .RegWr     (RegWr),
        .Rw        (Rw),
        .busW      (busW),
        .Ra        (Ra),
        .Rb        (Rb),
        .hitA      (hitA),
        .hitB      (hitB),
        .fwdA      (fwdA),
        .fwdB      (fwdB),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: commits on the edge after RegWr is seen.
    always @(posedge clk) begin
        if (RegWr) rf[Rw] <= busW;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_rw = '0; in_data = '0;
        port_free = 1'b0; Ra = '0; Rb = '0;
        repeat (3) tick();
        n_checks++;
        if ({RegWr, Rw, busW} !== 38'd0) $display("FAIL reset_out act=%0h exp=0", {RegWr, Rw, busW});
        else n_pass++;
        n_checks++;
        if ({count, empty, full, in_ready} !== {3'd0, 1'b1, 1'b0, 1'b1})
            $display("FAIL reset_status act=%0h exp=%0h", {count, empty, full, in_ready}, {3'd0, 3'b101});
        else n_pass++;
        n_checks++;
        if ({hitA, hitB, fwdA, fwdB} !== 66'd0) $display("FAIL reset_fwd act=%0h exp=0", {hitA, hitB, fwdA, fwdB});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        port_free = 1'b1; Ra = 5'd1; Rb = 5'd0;
        in_valid = 1'b1; in_rw = 5'd1; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (hitA !== 1'b1 || fwdA !== 32'hDEADBEEF || RegWr !== 1'b0)
            $display("FAIL single_fwd act=%b/%h/%b exp=1/deadbeef/0", hitA, fwdA, RegWr);
        else n_pass++;
        tick();
        n_checks++;
        if (RegWr !== 1'b1 || Rw !== 5'd1 || busW !== 32'hDEADBEEF || count !== 3'd0)
            $display("FAIL single_drain act=%b/%0d/%h/%0d exp=1/1/deadbeef/0", RegWr, Rw, busW, count);
        else n_pass++;
        tick();
        n_checks++;
        if (RegWr !== 1'b0 || hitA !== 1'b0 || rf[1] !== 32'hDEADBEEF)
            $display("FAIL single_commit act=%b/%b/%h exp=0/0/deadbeef", RegWr, hitA, rf[1]);
        else n_pass++;
    endtask

    task automatic test_fill;
        port_free = 1'b0; Ra = 5'd0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_rw = 5'(k); in_data = 32'h100 + 32'(k);
            #1;
            n_checks++;
            if (in_ready !== (k <= 4)) $display("FAIL fill_ready k=%0d act=%b exp=%b", k, in_ready, (k <= 4));
            else n_pass++;
            tick();
        end
        n_checks++;
        if (count !== 3'd4 || full !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL fill_full act=%0d/%b/%b exp=4/1/0", count, full, in_ready);
        else n_pass++;
        port_free = 1'b1;
        tick();
        n_checks++;
        if (RegWr !== 1'b1 || Rw !== 5'd1 || count !== 3'd3)
            $display("FAIL fill_pop1 act=%b/%0d/%0d exp=1/1/3", RegWr, Rw, count);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (Rw !== 5'd2 || busW !== 32'h102 || count !== 3'd3)
            $display("FAIL fill_pop2 act=%0d/%h/%0d exp=2/102/3", Rw, busW, count);
        else n_pass++;
        for (int j = 3; j <= 5; j++) begin
            tick();
            n_checks++;
            if (RegWr !== 1'b1 || Rw !== 5'(j) || busW !== 32'h100 + 32'(j))
                $display("FAIL fill_pop j=%0d act=%b/%0d/%h exp=1/%0d/%h", j, RegWr, Rw, busW, j, 32'h100 + j);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (RegWr !== 1'b0 || empty !== 1'b1 || rf[5] !== 32'h105)
            $display("FAIL fill_end act=%b/%b/%h exp=0/1/105", RegWr, empty, rf[5]);
        else n_pass++;
    endtask

    task automatic test_forward;
        port_free = 1'b0; Ra = 5'd2; Rb = 5'd3;
        in_valid = 1'b1; in_rw = 5'd2; in_data = 32'h11;
        tick();
        n_checks++;
        if (hitA !== 1'b1 || fwdA !== 32'h11) $display("FAIL fwd_first act=%b/%h exp=1/11", hitA, fwdA);
        else n_pass++;
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (hitA !== 1'b1 || fwdA !== 32'h22 || hitB !== 1'b0 || fwdB !== 32'h0)
            $display("FAIL fwd_young act=%b/%h/%b/%h exp=1/22/0/0", hitA, fwdA, hitB, fwdB);
        else n_pass++;
        port_free = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (hitA !== 1'b1 || fwdA !== 32'h22 || RegWr !== 1'b1)
                $display("FAIL fwd_drain c=%0d act=%b/%h/%b exp=1/22/1", c, hitA, fwdA, RegWr);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (hitA !== 1'b0 || fwdA !== 32'h0 || rf[2] !== 32'h22)
            $display("FAIL fwd_clear act=%b/%h/%h exp=0/0/22", hitA, fwdA, rf[2]);
        else n_pass++;
    endtask

    task automatic test_r0;
        port_free = 1'b1; Ra = 5'd0; Rb = 5'd0;
        in_valid = 1'b1; in_rw = 5'd0; in_data = 32'hFFFFFFFF;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL r0_ready act=%b exp=1", in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1 || hitA !== 1'b0 || fwdA !== 32'h0)
            $display("FAIL r0_count act=%0d/%b/%b/%h exp=0/1/0/0", count, empty, hitA, fwdA);
        else n_pass++;
        tick();
        n_checks++;
        if (RegWr !== 1'b0) $display("FAIL r0_regwr act=%b exp=0", RegWr);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        port_free = 1'b0; Ra = 5'd0;
        for (int k = 6; k <= 7; k++) begin
            in_valid = 1'b1; in_rw = 5'(k); in_data = 32'hA000_0000 + 32'(k);
            tick();
        end
        port_free = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_rw = 5'(8 + i); in_data = 32'hA000_0000 + 32'(8 + i);
            tick();
            n_checks++;
            if (count !== 3'd2 || RegWr !== 1'b1 || Rw !== 5'(6 + i) || busW !== 32'hA000_0000 + 32'(6 + i))
                $display("FAIL b2b i=%0d act=%0d/%b/%0d/%h exp=2/1/%0d/%h", i, count, RegWr, Rw, busW,
                         6 + i, 32'hA000_0000 + 6 + i);
            else n_pass++;
        end
        in_valid = 1'b0;
        for (int j = 12; j <= 13; j++) begin
            tick();
            n_checks++;
            if (Rw !== 5'(j) || busW !== 32'hA000_0000 + 32'(j) || count !== 3'(13 - j))
                $display("FAIL b2b_tail j=%0d act=%0d/%h/%0d exp=%0d/%h/%0d", j, Rw, busW, count,
                         j, 32'hA000_0000 + j, 13 - j);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_reset_mid;
        port_free = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            in_valid = 1'b1; in_rw = 5'(k); in_data = 32'hC0 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        port_free = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (RegWr !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || Rw !== 5'd0 || busW !== 32'd0)
            $display("FAIL rst_mid act=%b/%0d/%b/%0d/%h exp=0/0/1/0/0", RegWr, count, empty, Rw, busW);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (RegWr !== 1'b0 || count !== 3'd0) $display("FAIL rst_release c=%0d act=%b/%0d exp=0/0", c, RegWr, count);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_r0();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_write_buffer
`default_nettype wire
